// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART: TX and RX state encodings.
// The parity states exist only when UART_PARITY_EN is defined; otherwise they are never entered.
package uart_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PARITY,
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PARITY,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; pointers carry one extra wrap bit.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata_c = mem[rd_ptr[PTR_W-1:0]];

  // Empty ignores a pop; full accepts a push only alongside a pop.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= wdata;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// UART transceiver: programmable baud tick, TX/RX FIFOs, oversampled mid-bit receiver.
// Define UART_PARITY_EN to add a parity bit (parity_odd in, rx_parity_err out).
module uart_core_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
`ifdef UART_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 rx_parity_err
`endif
);

  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);
  localparam int unsigned TICK_CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned HALF_BIT   = OVERSAMPLE / 2;

  // Baud tick: divider reloads from clk_div only on wrap.
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;

  assign tick_c = (div_cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_q   <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
      div_q   <= clk_div;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  logic                 txf_push_c;
  logic                 txf_pop_c;
  logic                 txf_full_c;
  logic                 txf_empty_c;
  logic [DATA_BITS-1:0] txf_head_c;

  assign tx_ready   = !txf_full_c;
  assign txf_push_c = tx_valid && !txf_full_c;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (txf_push_c),
    .wdata   (tx_data),
    .pop     (txf_pop_c),
    .rdata_c (txf_head_c),
    .full_c  (txf_full_c),
    .empty_c (txf_empty_c)
  );

  tx_state_t            tx_state;
  logic [TICK_CNT_W-1:0] tx_tcnt;
  logic [BIT_CNT_W-1:0]  tx_bcnt;
  logic [DATA_BITS-1:0]  tx_shreg;
  logic                  tx_bit_end_c;

  assign tx_bit_end_c = tick_c && (tx_tcnt == TICK_CNT_W'(OVERSAMPLE - 1));
  assign tx_busy      = (tx_state != T_IDLE) || !txf_empty_c;

  // A new frame is loaded from idle on any tick, or straight out of the stop bit.
  assign txf_pop_c = !txf_empty_c &&
                     ((tick_c && tx_state == T_IDLE) || (tx_bit_end_c && tx_state == T_STOP));

`ifdef UART_PARITY_EN
  logic tx_par;
  logic tx_head_par_c;
  assign tx_head_par_c = (^txf_head_c) ^ parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shreg <= '0;
      ser_tx   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_state == T_IDLE) begin
      if (txf_pop_c) begin
        tx_state <= T_START;
        tx_tcnt  <= '0;
        tx_shreg <= txf_head_c;
        ser_tx   <= 1'b0;
`ifdef UART_PARITY_EN
        tx_par   <= tx_head_par_c;
`endif
      end
    end else if (tick_c) begin
      if (!tx_bit_end_c) begin
        tx_tcnt <= tx_tcnt + TICK_CNT_W'(1);
      end else begin
        tx_tcnt <= '0;
        case (tx_state)
          T_START: begin
            tx_state <= T_DATA;
            tx_bcnt  <= '0;
            ser_tx   <= tx_shreg[0];
          end
          T_DATA: begin
            if (tx_bcnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state <= T_PARITY;
              ser_tx   <= tx_par;
`else
              tx_state <= T_STOP;
              ser_tx   <= 1'b1;
`endif
            end else begin
              tx_bcnt  <= tx_bcnt + BIT_CNT_W'(1);
              tx_shreg <= tx_shreg >> 1;
              ser_tx   <= tx_shreg[1];
            end
          end
`ifdef UART_PARITY_EN
          T_PARITY: begin
            tx_state <= T_STOP;
            ser_tx   <= 1'b1;
          end
`endif
          T_STOP: begin
            if (txf_pop_c) begin
              tx_state <= T_START;
              tx_shreg <= txf_head_c;
              ser_tx   <= 1'b0;
`ifdef UART_PARITY_EN
              tx_par   <= tx_head_par_c;
`endif
            end else begin
              tx_state <= T_IDLE;
              ser_tx   <= 1'b1;
            end
          end
          default: begin
            tx_state <= T_IDLE;
            ser_tx   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  logic rx_s1;
  logic rx_s2;
  logic rx_s3;
  logic rx_fall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall_c = rx_s3 && !rx_s2;

  rx_state_t             rx_state;
  logic [TICK_CNT_W-1:0] rx_tcnt;
  logic [BIT_CNT_W-1:0]  rx_bcnt;
  logic [DATA_BITS-1:0]  rx_shreg;
  logic                  rx_samp_c;
  logic                  rxf_push_c;
  logic                  rxf_pop_c;
  logic                  rxf_full_c;
  logic                  rxf_empty_c;

  // Start is checked half a bit in; every later sample lands a full bit after the previous one.
  assign rx_samp_c = tick_c &&
                     ((rx_state == R_START) ? (rx_tcnt == TICK_CNT_W'(HALF_BIT - 1))
                                            : (rx_tcnt == TICK_CNT_W'(OVERSAMPLE - 1)));

`ifdef UART_PARITY_EN
  logic rx_par_ok;
  assign rxf_push_c = (rx_state == R_STOP) && rx_samp_c && rx_s2 && rx_par_ok;
`else
  assign rxf_push_c = (rx_state == R_STOP) && rx_samp_c && rx_s2;
`endif

  assign rx_valid  = !rxf_empty_c;
  assign rxf_pop_c = rx_valid && rx_ready;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rxf_push_c),
    .wdata   (rx_shreg),
    .pop     (rxf_pop_c),
    .rdata_c (rx_data),
    .full_c  (rxf_full_c),
    .empty_c (rxf_empty_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= R_IDLE;
      rx_tcnt       <= '0;
      rx_bcnt       <= '0;
      rx_shreg      <= '0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok     <= 1'b1;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (rx_state == R_IDLE) begin
        if (rx_fall_c) begin
          rx_state <= R_START;
          rx_tcnt  <= '0;
        end
      end else if (tick_c) begin
        if (!rx_samp_c) begin
          rx_tcnt <= rx_tcnt + TICK_CNT_W'(1);
        end else begin
          rx_tcnt <= '0;
          case (rx_state)
            R_START: begin
              rx_state <= rx_s2 ? R_IDLE : R_DATA;
              rx_bcnt  <= '0;
            end
            R_DATA: begin
              rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
              if (rx_bcnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                rx_state <= R_PARITY;
`else
                rx_state <= R_STOP;
`endif
              end else begin
                rx_bcnt <= rx_bcnt + BIT_CNT_W'(1);
              end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
              rx_state  <= R_STOP;
              rx_par_ok <= (((^rx_shreg) ^ parity_odd) == rx_s2);
            end
`endif
            R_STOP: begin
              // Edge-triggered re-arm: a stuck-low line after a bad stop cannot restart a frame.
              rx_state <= R_IDLE;
              if (!rx_s2) begin
                rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              end else if (!rx_par_ok) begin
                rx_parity_err <= 1'b1;
`endif
              end else if (rxf_full_c && !rxf_pop_c) begin
                rx_overrun <= 1'b1;
              end
            end
            default: rx_state <= R_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: loopback scoreboard, flag pulse counters, reset abort.
// Builds with or without UART_PARITY_EN.
module tb_uart_core_param;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11 * OS;
`else
  localparam int FRAME = 10 * OS;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   clk_div;
  logic          tx_valid;
  logic [DB-1:0] tx_data;
  logic          tx_ready;
  logic          tx_busy;
  logic          ser_tx;
  logic          ser_rx;
  logic          rx_valid;
  logic [DB-1:0] rx_data;
  logic          rx_ready;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          loop_en;
  logic          drv_rx;
`ifdef UART_PARITY_EN
  logic          parity_odd;
  logic          rx_parity_err;
  logic          par_force;
  logic          par_val;
  int            pe_cnt;
`endif

  int n_tests, n_fail;
  int fe_cnt, ov_cnt, both_cnt;
  int cyc, last_fall;
  logic ser_tx_d;
  logic [DB-1:0] exp_q [$];

  assign ser_rx = loop_en ? ser_tx : drv_rx;

  always #5 clk = ~clk;

  uart_core_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_div      (clk_div),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
`ifdef UART_PARITY_EN
    ,
    .parity_odd   (parity_odd),
    .rx_parity_err(rx_parity_err)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Flag pulse counters and TX start-edge timestamp.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_frame_err) fe_cnt++;
      if (rx_overrun) ov_cnt++;
      if (rx_frame_err && rx_overrun) both_cnt++;
`ifdef UART_PARITY_EN
      if (rx_parity_err) pe_cnt++;
`endif
      if (ser_tx_d && !ser_tx) last_fall = cyc;
    end
    ser_tx_d = ser_tx;
  end

  task automatic push_tx(input logic [DB-1:0] d, input bit expect_rx);
    int budget;
    budget = 4 * FRAME;
    while (!tx_ready && budget > 0) begin @(negedge clk); budget--; end
    if (!tx_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_tx_timeout: tx_ready=%b, required 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    if (expect_rx) exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop);
    drv_rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      drv_rx = d[i];
      repeat (OS) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    drv_rx = par_force ? par_val : ((^d) ^ parity_odd);
    repeat (OS) @(negedge clk);
`endif
    drv_rx = stop;
    repeat (OS) @(negedge clk);
    drv_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_div = '0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b1; drv_rx = 1'b1;
`ifdef UART_PARITY_EN
    parity_odd = 1'b0; par_force = 1'b0; par_val = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_tests++; if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL reset_ser_tx: got %b, required 1", ser_tx); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b, required 0", tx_busy); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    n_tests++;
    if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got fe=%b ov=%b, required 0 0", rx_frame_err, rx_overrun);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback(input logic [15:0] div, input logic [DB-1:0] d, input int exp_low);
    int t, t0, tv, low, lo, hi, budget, lat;
    bit in_start;
    logic [DB-1:0] exp;
    t = 0; t0 = -1; tv = -1; low = 0; in_start = 1'b0;
    lo = (FRAME - OS / 2) * (int'(div) + 1);
    hi = lo + int'(div) + 9;
    budget = 2 * FRAME * (int'(div) + 1) + 50;
    loop_en = 1'b1;
    clk_div = div;
    repeat (4) @(negedge clk);
    push_tx(d, 1'b1);
    while (tv < 0 && t < budget) begin
      if (t0 < 0 && ser_tx === 1'b0) begin t0 = t; in_start = 1'b1; end
      if (in_start) begin
        if (ser_tx === 1'b0) low++;
        else in_start = 1'b0;
      end
      if (rx_valid === 1'b1) tv = t;
      else begin @(negedge clk); t++; end
    end
    lat = tv - t0;
    n_tests++;
    if (low != exp_low) begin n_fail++; $display("FAIL loop_start_len div=%0d: got %0d clk, required %0d", div, low, exp_low); end
    n_tests++;
    if (t0 < 0 || tv < 0 || lat < lo || lat > hi) begin
      n_fail++; $display("FAIL loop_latency div=%0d: got %0d clk, required %0d..%0d", div, lat, lo, hi);
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      n_fail++; $display("FAIL loop_data div=%0d: got valid=%b data=%h, required %h", div, rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    clk_div = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] vals [4];
    logic [DB-1:0] exp;
    int t0, off, w;
    vals = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    loop_en = 1'b1; clk_div = '0;
    for (int i = 0; i < 4; i++) push_tx(vals[i], 1'b1);
    t0 = last_fall;
    off = cyc - t0;
    while (off < 4 * FRAME + 3) begin
      @(negedge clk);
      off = cyc - t0;
      for (int k = 0; k < 4; k++) begin
        if (off == k * FRAME + OS / 2) begin
          n_tests++;
          if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start[%0d]: ser_tx=%b, required 0", k, ser_tx); end
        end
        if (off == (k + 1) * FRAME - OS / 2) begin
          n_tests++;
          if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_stop[%0d]: ser_tx=%b, required 1", k, ser_tx); end
        end
      end
    end
    n_tests++;
    if (tx_busy !== 1'b0 || ser_tx !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: tx_busy=%b ser_tx=%b, required 0 1", tx_busy, ser_tx);
    end
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!rx_valid && w < 2 * FRAME) begin @(negedge clk); w++; end
      exp = exp_q.pop_front();
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_fail++; $display("FAIL b2b_rx[%0d]: got valid=%b data=%h, required %h", i, rx_valid, rx_data, exp);
      end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
  endtask

  task automatic test_overrun();
    int ov0, fe0, w;
    logic [DB-1:0] exp;
    ov0 = ov_cnt; fe0 = fe_cnt;
    loop_en = 1'b1; rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_tx(DB'(i), i <= 4);
    w = 0;
    while (tx_busy && w < 8 * FRAME) begin @(negedge clk); w++; end
    repeat (FRAME) @(negedge clk);
    n_tests++;
    if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d, required 1", ov_cnt - ov0); end
    n_tests++;
    if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL overrun_frame_err: got %0d pulses, required 0", fe_cnt - fe0); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_fail++; $display("FAIL overrun_rx[%0d]: got valid=%b data=%h, required %h", i, rx_valid, rx_data, exp);
      end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    n_tests++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drained: rx_valid=%b, required 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    int fe0, ov0;
    loop_en = 1'b0; drv_rx = 1'b1; clk_div = '0;
    repeat (4) @(negedge clk);
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_frame(8'h81, 1'b0);
    repeat (3 * OS) @(negedge clk);
    n_tests++;
    if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frame_err_pulses: got %0d, required 1", fe_cnt - fe0); end
    n_tests++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_err_dropped: rx_valid=%b, required 0", rx_valid); end
    fe0 = fe_cnt;
    drv_rx = 1'b0; repeat (3) @(negedge clk); drv_rx = 1'b1;
    repeat (2 * OS) @(negedge clk);
    n_tests++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch: fe+%0d ov+%0d rx_valid=%b, required 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rx_valid);
    end
    loop_en = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int pe0;
    logic [DB-1:0] exp;
    loop_en = 1'b0; drv_rx = 1'b1; parity_odd = 1'b0;
    pe0 = pe_cnt;
    par_force = 1'b1; par_val = 1'b0;
    drive_frame(8'h07, 1'b1);
    repeat (2 * OS) @(negedge clk);
    n_tests++;
    if (pe_cnt - pe0 != 1) begin n_fail++; $display("FAIL parity_err_pulses: got %0d, required 1", pe_cnt - pe0); end
    n_tests++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL parity_dropped: rx_valid=%b, required 0", rx_valid); end
    parity_odd = 1'b1; par_force = 1'b0;
    exp_q.push_back(8'h07);
    drive_frame(8'h07, 1'b1);
    repeat (2 * OS) @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      n_fail++; $display("FAIL parity_odd_good: got valid=%b data=%h, required %h", rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    parity_odd = 1'b0; loop_en = 1'b1;
  endtask
`endif

  task automatic test_reset_midframe();
    loop_en = 1'b1; clk_div = '0;
    push_tx(8'h00, 1'b0);
    push_tx(8'h11, 1'b0);
    push_tx(8'h22, 1'b0);
    repeat (40) @(negedge clk);
    n_tests++;
    if (ser_tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL midframe_pre: ser_tx=%b tx_busy=%b, required 0 1", ser_tx, tx_busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset: ser_tx=%b tx_busy=%b rx_valid=%b, required 1 0 0", ser_tx, tx_busy, rx_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    n_tests++;
    if (rx_valid !== 1'b0 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_lost: rx_valid=%b tx_busy=%b, required 0 0", rx_valid, tx_busy);
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL flags_exclusive: %0d cycles with both, required 0", both_cnt); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: %0d words, required 0", exp_q.size()); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; fe_cnt = 0; ov_cnt = 0; both_cnt = 0;
    cyc = 0; last_fall = 0; ser_tx_d = 1'b1;
`ifdef UART_PARITY_EN
    pe_cnt = 0;
`endif
    test_reset();
    test_loopback(16'd0, 8'h55, 16);
    test_loopback(16'd3, 8'hC3, 64);
    test_back_to_back();
    test_overrun();
    test_frame_err();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
